// File: rtl/ysyx_22050019_pkg.sv
// Shared constants for the IFU/LSU read arbiter: FSM encodings, master indices, response codes.
package ysyx_22050019_pkg;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_AR    = 2'd1;
    localparam logic [1:0] ARB_R     = 2'd2;

    localparam logic       ARB_M_IFU = 1'b0;
    localparam logic       ARB_M_LSU = 1'b1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = ARB_IDLE,
        ST_AR   = ARB_AR,
        ST_R    = ARB_R
    } arb_state_e;

endpackage

// File: rtl/ysyx_22050019_arb_pick.sv
// Combinational 2-way picker. YSYX_22050019_ARB_RR_EN selects round-robin on contention;
// otherwise the LSU always beats the IFU.
module ysyx_22050019_arb_pick
    import ysyx_22050019_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       gnt_idx_o,
    output logic       gnt_vld_o
);

    assign gnt_vld_o = |req_i;

`ifdef YSYX_22050019_ARB_RR_EN
    // On contention the master that did not win last time goes first.
    always_comb begin
        gnt_idx_o = ARB_M_IFU;
        if (&req_i)
            gnt_idx_o = ~last_i;
        else if (req_i[ARB_M_LSU])
            gnt_idx_o = ARB_M_LSU;
    end
`else
    logic unused_last;
    assign unused_last = last_i;
    assign gnt_idx_o   = req_i[ARB_M_LSU] ? ARB_M_LSU : ARB_M_IFU;
`endif

endmodule

// File: rtl/ysyx_22050019_axi_rd_arb.sv
// Two-master (IFU=0, LSU=1) single-outstanding AXI-Lite read arbiter onto one slave port.
// Define YSYX_22050019_ARB_RR_EN for round-robin arbitration; default is fixed LSU priority.
module ysyx_22050019_axi_rd_arb
    import ysyx_22050019_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_arvalid,
    input  logic [ADDR_W-1:0] m0_araddr,
    output logic              m0_arready,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    input  logic              m0_rready,
    input  logic              m1_arvalid,
    input  logic [ADDR_W-1:0] m1_araddr,
    output logic              m1_arready,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    input  logic              m1_rready,
    output logic              s_arvalid,
    output logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arready,
    input  logic              s_rvalid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    output logic              s_rready,
    output logic              grant_o,
    output logic              busy_o
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              grant_q, grant_d;
    logic              last;
    logic              pick_idx, pick_vld, accept, sel_rready;

    ysyx_22050019_arb_pick u_pick (
        .req_i    ({m1_arvalid, m0_arvalid}),
        .last_i   (last),
        .gnt_idx_o(pick_idx),
        .gnt_vld_o(pick_vld)
    );

    // rst_n is active-high: no grant may escape during the reset cycle.
    assign accept = (state_q == ST_IDLE) && pick_vld && !rst_n;

`ifdef YSYX_22050019_ARB_RR_EN
    logic last_q;
    always_ff @(posedge clk) begin
        if (rst_n)
            last_q <= ARB_M_LSU;
        else if (accept)
            last_q <= pick_idx;
    end
    assign last = last_q;
`else
    assign last = ARB_M_LSU;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                addr_d  = pick_idx ? m1_araddr : m0_araddr;
                grant_d = pick_idx;
                state_d = ST_AR;
            end
            ST_AR:   if (s_arready) state_d = ST_R;
            ST_R:    if (s_rvalid && s_rready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            grant_q <= ARB_M_IFU;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            grant_q <= grant_d;
        end
    end

    assign m0_arready = accept && (pick_idx == ARB_M_IFU);
    assign m1_arready = accept && (pick_idx == ARB_M_LSU);

    assign s_arvalid  = (state_q == ST_AR);
    assign s_araddr   = addr_q;

    assign sel_rready = grant_q ? m1_rready : m0_rready;
    assign s_rready   = (state_q == ST_R) && sel_rready;
    assign m0_rvalid  = (state_q == ST_R) && (grant_q == ARB_M_IFU) && s_rvalid;
    assign m1_rvalid  = (state_q == ST_R) && (grant_q == ARB_M_LSU) && s_rvalid;
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;
    assign m0_rresp   = s_rresp;
    assign m1_rresp   = s_rresp;

    assign grant_o    = grant_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ysyx_22050019_axi_rd_arb.sv
// Self-checking bench for the IFU/LSU read arbiter (honours YSYX_22050019_ARB_RR_EN if defined).
module tb_ysyx_22050019_axi_rd_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
    logic [63:0] m0_araddr, m1_araddr, m0_rdata, m1_rdata;
    logic        m0_rvalid, m1_rvalid, m0_rready, m1_rready;
    logic [1:0]  m0_rresp, m1_rresp, s_rresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, grant_o, busy_o;
    logic [63:0] s_araddr, s_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_22050019_axi_rd_arb #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arready(m0_arready),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
        .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arready(m1_arready),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    // Arbitration rule from the master's point of view; returns -1 when nobody asks.
    function automatic int pick_exp(logic v0, logic v1, logic last);
`ifdef YSYX_22050019_ARB_RR_EN
        if (v0 && v1) return last ? 0 : 1;
`else
        if (v0 && v1) return last ? 1 : 1;  // fixed priority ignores history
`endif
        if (v1) return 1;
        if (v0) return 0;
        return -1;
    endfunction

    function automatic logic [63:0] datafn(logic [63:0] a);
        return {a[31:0], a[63:32]} ^ 64'hA5A5_5A5A_0F0F_F0F0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        m0_arvalid = 0; m1_arvalid = 0; m0_araddr = '0; m1_araddr = '0;
        m0_rready = 0; m1_rready = 0;
        s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = 2'b00;
    endtask

    task automatic reset_pulse();
        idle_in();
        rst_n = 1;
        step();
        rst_n = 0;
    endtask

    // Runs one full transaction assuming requests are already being driven.
    task automatic serve(input logic drop_loser, input logic [1:0] resp,
                         output int who, output logic [63:0] a_seen,
                         output logic [63:0] d_seen, output logic [1:0] r_seen,
                         output logic other_rv);
        @(negedge clk);
        who = m1_arready ? 1 : (m0_arready ? 0 : -1);
        step();
        if (drop_loser) begin m0_arvalid = 0; m1_arvalid = 0; end
        else if (who == 1) m1_arvalid = 0;
        else if (who == 0) m0_arvalid = 0;
        s_arready = 1;
        @(negedge clk);
        a_seen = s_arvalid ? s_araddr : 'x;
        step();
        s_arready = 0; s_rvalid = 1; s_rdata = ~a_seen; s_rresp = resp;
        m0_rready = 1; m1_rready = 1;
        @(negedge clk);
        if (who == 1) begin
            d_seen = m1_rvalid ? m1_rdata : 'x; r_seen = m1_rresp; other_rv = m0_rvalid;
        end else begin
            d_seen = m0_rvalid ? m0_rdata : 'x; r_seen = m0_rresp; other_rv = m1_rvalid;
        end
        step();
        s_rvalid = 0; m0_rready = 0; m1_rready = 0;
    endtask

    task automatic test_reset();
        idle_in();
        rst_n = 1;
        step(); step();
        rst_n = 0;
        @(negedge clk);
        total++;
        if ({busy_o, grant_o, s_arvalid, s_rready, m0_rvalid, m1_rvalid, m0_arready, m1_arready} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=00000000",
                     {busy_o, grant_o, s_arvalid, s_rready, m0_rvalid, m1_rvalid, m0_arready, m1_arready});
        end
        total++;
        if (s_araddr !== 64'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", s_araddr); end
        step();
    endtask

    task automatic test_single_ifu();
        m0_arvalid = 1; m0_araddr = 64'h8000_0000;
        @(negedge clk);
        total++;
        if ({m1_arready, m0_arready} !== 2'b01) begin bad++; $display("FAIL ifu_arready got=%b want=01", {m1_arready, m0_arready}); end
        step();
        m0_arvalid = 0; s_arready = 1;
        @(negedge clk);
        total++;
        if (s_arvalid !== 1'b1 || s_araddr !== 64'h8000_0000) begin
            bad++; $display("FAIL ifu_s_araddr got=%b/%h want=1/80000000", s_arvalid, s_araddr);
        end
        total++;
        if ({grant_o, busy_o, m1_rvalid} !== 3'b010) begin bad++; $display("FAIL ifu_grant_busy got=%b want=010", {grant_o, busy_o, m1_rvalid}); end
        step();
        s_arready = 0; s_rvalid = 1; s_rdata = 64'h0000_0013_0000_0093; s_rresp = 2'b00; m0_rready = 1;
        @(negedge clk);
        total++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 64'h0000_0013_0000_0093 || m0_rresp !== 2'b00) begin
            bad++; $display("FAIL ifu_rdata got=%b/%h/%b want=1/0000001300000093/00", m0_rvalid, m0_rdata, m0_rresp);
        end
        total++;
        if ({m1_rvalid, s_rready} !== 2'b01) begin bad++; $display("FAIL ifu_route got=%b want=01", {m1_rvalid, s_rready}); end
        step();
        idle_in();
        @(negedge clk);
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL ifu_done_busy got=%b want=0", busy_o); end
        step();
    endtask

    task automatic test_contention();
        int          who, exp;
        logic        last_m, orv;
        logic [63:0] a, d;
        logic [1:0]  r;
        reset_pulse();
        last_m = 1'b1;
        for (int k = 0; k < 3; k++) begin
            m0_arvalid = 1; m0_araddr = 64'h8000_0004;
            m1_arvalid = 1; m1_araddr = 64'h8000_1000;
            serve(1'b1, 2'b00, who, a, d, r, orv);
            exp = pick_exp(1'b1, 1'b1, last_m);
            last_m = exp[0];
            total++;
            if (who !== exp) begin bad++; $display("FAIL round%0d_winner got=%0d want=%0d", k, who, exp); end
            total++;
            if (a !== (exp == 1 ? 64'h8000_1000 : 64'h8000_0004)) begin
                bad++; $display("FAIL round%0d_addr got=%h want=%h", k, a, (exp == 1 ? 64'h8000_1000 : 64'h8000_0004));
            end
        end
        // Loser keeps arvalid up and must be served next.
        m0_arvalid = 1; m0_araddr = 64'h8000_0004;
        m1_arvalid = 1; m1_araddr = 64'h8000_1000;
        exp = pick_exp(1'b1, 1'b1, last_m);
        serve(1'b0, 2'b00, who, a, d, r, orv);
        total++;
        if (who !== exp || a !== 64'h8000_1000 || d !== ~64'h8000_1000) begin
            bad++; $display("FAIL hold_first got=%0d/%h/%h want=%0d/80001000/%h", who, a, d, exp, ~64'h8000_1000);
        end
        serve(1'b0, 2'b00, who, a, d, r, orv);
        total++;
        if (who !== 0 || a !== 64'h8000_0004 || d !== ~64'h8000_0004 || orv !== 1'b0) begin
            bad++; $display("FAIL hold_second got=%0d/%h/%h/%b want=0/80000004/%h/0", who, a, d, orv, ~64'h8000_0004);
        end
        idle_in();
    endtask

    task automatic test_backpressure();
        m0_arvalid = 1; m0_araddr = 64'h8000_0040;
        @(negedge clk);
        total++;
        if (m0_arready !== 1'b1) begin bad++; $display("FAIL bp_arready got=%b want=1", m0_arready); end
        step();
        m0_arvalid = 0; s_arready = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (s_arvalid !== 1'b1 || s_araddr !== 64'h8000_0040) begin
                bad++; $display("FAIL bp_ar_stable%0d got=%b/%h want=1/80000040", i, s_arvalid, s_araddr);
            end
            step();
        end
        s_arready = 1;
        step();
        s_arready = 0; s_rvalid = 1; s_rdata = 64'hDEAD_BEEF_0BAD_F00D; m0_rready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({s_rready, busy_o, m0_rvalid} !== 3'b011) begin
                bad++; $display("FAIL bp_r_hold%0d got=%b want=011", i, {s_rready, busy_o, m0_rvalid});
            end
            step();
        end
        m0_rready = 1;
        @(negedge clk);
        total++;
        if (s_rready !== 1'b1 || m0_rdata !== 64'hDEAD_BEEF_0BAD_F00D) begin
            bad++; $display("FAIL bp_r_release got=%b/%h want=1/deadbeef0badf00d", s_rready, m0_rdata);
        end
        step();
        idle_in();
        @(negedge clk);
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL bp_done_busy got=%b want=0", busy_o); end
        step();
    endtask

    task automatic test_reset_mid_r();
        m1_arvalid = 1; m1_araddr = 64'h0000_0000_8000_2000;
        step();
        m1_arvalid = 0; s_arready = 1;
        step();
        s_arready = 0; m1_rready = 1;
        @(negedge clk);
        total++;
        if ({busy_o, grant_o} !== 2'b11) begin bad++; $display("FAIL rst_mid_pre got=%b want=11", {busy_o, grant_o}); end
        step();
        rst_n = 1; s_rvalid = 1; s_rdata = 64'h1111_2222_3333_4444;
        step();
        rst_n = 0; m0_arvalid = 1; m0_araddr = 64'h8000_0100;
        @(negedge clk);
        total++;
        if ({busy_o, s_rready, s_arvalid, m1_rvalid, m0_arready} !== 5'b00001) begin
            bad++; $display("FAIL rst_mid_after got=%b want=00001", {busy_o, s_rready, s_arvalid, m1_rvalid, m0_arready});
        end
        step();
        m0_arvalid = 0; s_rvalid = 0; s_arready = 1; m1_rready = 0;
        @(negedge clk);
        total++;
        if (s_araddr !== 64'h8000_0100 || grant_o !== 1'b0) begin
            bad++; $display("FAIL rst_mid_newaddr got=%h/%b want=80000100/0", s_araddr, grant_o);
        end
        step();
        s_arready = 0; s_rvalid = 1; s_rdata = 64'h5555_6666_7777_8888; m0_rready = 1;
        @(negedge clk);
        total++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 64'h5555_6666_7777_8888) begin
            bad++; $display("FAIL rst_mid_newdata got=%b/%h want=1/5555666677778888", m0_rvalid, m0_rdata);
        end
        step();
        idle_in();
    endtask

    task automatic test_error_resp();
        int          who;
        logic        orv;
        logic [63:0] a, d;
        logic [1:0]  r;
        m1_arvalid = 1; m1_araddr = 64'h8000_3008;
        serve(1'b1, 2'b10, who, a, d, r, orv);
        total++;
        if (who !== 1 || r !== 2'b10 || d !== ~64'h8000_3008 || orv !== 1'b0) begin
            bad++; $display("FAIL err_resp got=%0d/%b/%h/%b want=1/10/%h/0", who, r, d, orv, ~64'h8000_3008);
        end
        @(negedge clk);
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL err_idle got=%b want=0", busy_o); end
        step();
    endtask

    // Random traffic from both masters against a transaction-level model.
    task automatic test_random();
        logic [1:0]  pend, waiting;
        logic [63:0] maddr [2];
        int          stage, w, sl_delay;
        logic        owner, last_m, rr_own;
        logic [1:0]  exp_arr, exp_rv;
        logic [63:0] got_d;
        logic [1:0]  got_r;
        reset_pulse();
        pend = 0; waiting = 0; maddr[0] = '0; maddr[1] = '0;
        stage = 0; owner = 0; last_m = 1; sl_delay = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            w       = (stage == 0) ? pick_exp(m0_arvalid, m1_arvalid, last_m) : -1;
            exp_arr = (w == 1) ? 2'b10 : ((w == 0) ? 2'b01 : 2'b00);
            rr_own  = owner ? m1_rready : m0_rready;
            exp_rv  = 2'b00;
            if (stage == 2 && s_rvalid) exp_rv[owner] = 1'b1;
            total++;
            if ({m1_arready, m0_arready} !== exp_arr) begin
                bad++; $display("FAIL rnd_arready cyc=%0d got=%b want=%b", cyc, {m1_arready, m0_arready}, exp_arr);
            end
            total++;
            if (s_arvalid !== (stage == 1) || (stage == 1 && s_araddr !== maddr[owner])) begin
                bad++; $display("FAIL rnd_ar cyc=%0d got=%b/%h want=%b/%h", cyc, s_arvalid, s_araddr, stage == 1, maddr[owner]);
            end
            total++;
            if ({m1_rvalid, m0_rvalid} !== exp_rv || s_rready !== (stage == 2 && rr_own)) begin
                bad++; $display("FAIL rnd_r cyc=%0d got=%b/%b want=%b/%b", cyc, {m1_rvalid, m0_rvalid}, s_rready, exp_rv, stage == 2 && rr_own);
            end
            total++;
            if (busy_o !== (stage != 0) || (stage != 0 && grant_o !== owner)) begin
                bad++; $display("FAIL rnd_busy cyc=%0d got=%b/%b want=%b/%b", cyc, busy_o, grant_o, stage != 0, owner);
            end
            if (stage == 2 && s_rvalid && rr_own) begin
                got_d = owner ? m1_rdata : m0_rdata;
                got_r = owner ? m1_rresp : m0_rresp;
                total++;
                if (got_d !== datafn(maddr[owner]) || got_r !== maddr[owner][5:4]) begin
                    bad++; $display("FAIL rnd_data cyc=%0d m%0d got=%h/%b want=%h/%b", cyc, owner, got_d, got_r,
                                    datafn(maddr[owner]), maddr[owner][5:4]);
                end
            end
            if (w >= 0) begin
                owner = w[0]; last_m = w[0]; stage = 1;
                pend[w[0]] = 0; waiting[w[0]] = 1;
            end else if (stage == 1 && s_arready) begin
                stage = 2; sl_delay = $urandom_range(0, 3);
            end else if (stage == 2 && s_rvalid && rr_own) begin
                stage = 0; waiting[owner] = 0;
            end
            step();
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && !waiting[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1; maddr[i] = {$urandom, $urandom};
                end else if (pend[i] && $urandom_range(0, 19) == 0) begin
                    pend[i] = 0;
                end
            end
            m0_arvalid = pend[0]; m0_araddr = pend[0] ? maddr[0] : {$urandom, $urandom};
            m1_arvalid = pend[1]; m1_araddr = pend[1] ? maddr[1] : {$urandom, $urandom};
            m0_rready  = ($urandom_range(0, 9) < 7);
            m1_rready  = ($urandom_range(0, 9) < 7);
            s_arready  = $urandom_range(0, 1) == 1;
            if (stage == 2) begin
                if (sl_delay > 0) begin sl_delay--; s_rvalid = 0; end
                else s_rvalid = 1;
                s_rdata = datafn(maddr[owner]); s_rresp = maddr[owner][5:4];
            end else begin
                s_rvalid = 0; s_rdata = {$urandom, $urandom}; s_rresp = 2'($urandom_range(0, 3));
            end
        end
        idle_in();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_in();
        rst_n = 1;
        step(); step();
        test_reset();
        test_single_ifu();
        test_contention();
        test_backpressure();
        test_reset_mid_r();
        test_error_resp();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
